// File: rtl/disp_scan4_if.sv
// Digit/segment bundle between the BCD counter chain and the 4-digit multiplexed display.
interface disp_scan4_if;
  logic [3:0] Q0;
  logic [3:0] Q1;
  logic [3:0] Q2;
  logic [3:0] Q3;
  logic       Blank_En;
  logic [3:0] Dp_In;
  logic [6:0] Seg;
  logic       Dp;
  logic [3:0] Dig;
  logic       Frame;

  modport master (
    output Q0, Q1, Q2, Q3, Blank_En, Dp_In,
    input  Seg, Dp, Dig, Frame
  );

  modport slave (
    input  Q0, Q1, Q2, Q3, Blank_En, Dp_In,
    output Seg, Dp, Dig, Frame
  );
endinterface

// File: rtl/disp_scan4.sv
// Four-digit multiplexed 7-segment scanner with frame-coherent snapshot and
// leading-zero blanking; all outputs registered and updated together on the slot tick.
module disp_scan4 #(
  parameter int unsigned DIV = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  disp_scan4_if.slave bus
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    idx;
  logic [1:0]    nidx;
  logic [3:0]    s1, s2, s3;
  logic [3:0]    digv;
  logic          blank;

  logic [6:0]    seg_r;
  logic          dp_r;
  logic [3:0]    dig_r;
  logic          frame_r;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  assign tick = (presc == LAST);
  assign nidx = idx + 2'd1;

  // Digit 0 is decoded from the live value at the capture edge, so only
  // digits 1..3 need to be held in the snapshot.
  always_comb begin
    digv  = '0;
    blank = 1'b0;
    case (nidx)
      2'd0: begin
        digv  = bus.Q0;
        blank = 1'b0;
      end
      2'd1: begin
        digv  = s1;
        blank = bus.Blank_En && (s3 == 4'd0) && (s2 == 4'd0) && (s1 == 4'd0);
      end
      2'd2: begin
        digv  = s2;
        blank = bus.Blank_En && (s3 == 4'd0) && (s2 == 4'd0);
      end
      default: begin
        digv  = s3;
        blank = bus.Blank_En && (s3 == 4'd0);
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc   <= '0;
      idx     <= 2'd3;
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      dig_r   <= '1;
      seg_r   <= '0;
      dp_r    <= 1'b0;
      frame_r <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx     <= nidx;
        dig_r   <= ~(4'b0001 << nidx);
        seg_r   <= blank ? 7'h00 : seg7(digv);
        dp_r    <= bus.Dp_In[nidx];
        frame_r <= (nidx == 2'd0);
        if (nidx == 2'd0) begin
          s1 <= bus.Q1;
          s2 <= bus.Q2;
          s3 <= bus.Q3;
        end
      end else begin
        frame_r <= 1'b0;
      end
    end
  end

  assign bus.Seg   = seg_r;
  assign bus.Dp    = dp_r;
  assign bus.Dig   = dig_r;
  assign bus.Frame = frame_r;

endmodule

// File: doc/disp_scan4.md
DISP_SCAN4 -- requirements
Module: disp_scan4

Interface
REQ-001 Parameter DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 Clk  input  1  single system clock, all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Q0  input  4  BCD units digit from the 4-digit counter chain.
REQ-005 Q1  input  4  BCD tens digit.
REQ-006 Q2  input  4  BCD hundreds digit.
REQ-007 Q3  input  4  BCD thousands digit.
REQ-008 Blank_En  input  1  leading-zero blanking enable.
REQ-009 Dp_In  input  4  per-digit decimal point request; bit n for digit n, active-high.
REQ-010 Seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
REQ-011 Dp  output  1  decimal point drive for the selected digit, active-high, registered.
REQ-012 Dig  output  4  digit select, one-hot active-low (bit n low selects digit n), registered.
REQ-013 Frame  output  1  one-cycle pulse marking the start of each scan frame, registered.

Function
REQ-014 The prescaler SHALL count 0..DIV-1 and wrap; tick is asserted in the cycle the prescaler equals DIV-1.
REQ-015 The 2-bit scan index SHALL advance only on tick, in the sequence 0,1,2,3,0, with 3 wrapping to 0.
REQ-016 The first tick after reset SHALL select digit 0.
REQ-017 On the edge where the index enters 0, all four inputs SHALL be captured into a snapshot register; for the whole frame, every digit SHALL display the snapshot, not live Q values, so a carry never tears a frame.
REQ-018 Digit 0 data on that same edge SHALL be decoded from the values being captured, so there is no one-frame lag.
REQ-019 On each tick edge, Dig, Seg, Dp and Frame SHALL all update together, with Dig = ~(1<<index); all outputs hold between ticks.
REQ-020 Decode (hex) SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-021 Any value 10..15 SHALL decode to 40 (dash only).
REQ-022 With Blank_En=1, digit 3 SHALL blank (Seg=00) if snapshot Q3=0.
REQ-023 With Blank_En=1, digit 2 SHALL blank if Q3=0 and Q2=0.
REQ-024 With Blank_En=1, digit 1 SHALL blank if Q3, Q2 and Q1 are all 0.
REQ-025 Digit 0 SHALL never blank; an invalid digit counts as non-zero for blanking.
REQ-026 Dp SHALL equal Dp_In[index] sampled on the tick edge, and SHALL remain driven when the digit is blanked.
REQ-027 Blank_En SHALL be sampled on the tick edge, so a change takes effect on the next digit slot.
REQ-028 Frame SHALL be 1 for exactly the one cycle after the edge entering index 0, and 0 otherwise.
REQ-029 Refresh period per digit SHALL be exactly DIV cycles; frame period SHALL be exactly 4*DIV cycles.

Reset
REQ-030 While Reset=1 at a rising edge, next state SHALL be: prescaler=0, index=3, snapshot=0, Dig=1111, Seg=00, Dp=0, Frame=0.
REQ-031 Reset SHALL take priority over tick.
REQ-032 A reset mid-frame SHALL abandon the frame; the next frame starts DIV cycles after Reset deasserts.

Verification (DIV=4)
REQ-033 Reset, then Q3..Q0=1,2,3,4 and Blank_En=0 -> first Dig=1110 with Seg=66 at cycle 4 after Reset low; then 1101/4F, 1011/5B, 0111/06, each held 4 cycles; Frame pulses every 16 cycles.
REQ-034 Q3..Q0=0,0,7,0 and Blank_En=1 -> digit 0 Seg=3F, digit 1 Seg=07, digits 2 and 3 Seg=00; same inputs with Blank_En=0 -> digits 2 and 3 Seg=3F.
REQ-035 Q0 changes 4->5 while digit 2 is displayed -> remainder of the frame unchanged; digit 0 of the next frame shows 6D.
REQ-036 Q1=4'hC -> digit 1 Seg=40 and is not blanked; Dp_In=0010 -> Dp=1 only during the digit 1 slot.
REQ-037 Assert Reset for 1 cycle during the digit 2 slot -> next edge Dig=1111, Seg=00, Frame=0; digit 0 reappears exactly 4 cycles after Reset low.
